reg_write_receiver: RTL and testbench



---
 rtl/reg_write_receiver.sv | 164 ++++++++++++++++
 tb/tb_reg_write_receiver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_receiver.sv
// Purpose: receive side of the 8-bit register-write bus; pairs low/high byte writes into 16-bit registers.
// Latency: regs_o/commit_o update SYNC_STAGES edges after strobe_i is first sampled high.
// Backpressure: none; the sender paces writes by strobe high/low times (SYNC_STAGES+1 cycles each).
module reg_write_receiver #(
    parameter int NUM_REGS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             data_i,
    input  logic [3:0]             addr_i,
    input  logic                   strobe_i,
    input  logic                   err_clr_i,
    output logic [16*NUM_REGS-1:0] regs_o,
    output logic                   commit_o,
    output logic [2:0]             commit_idx_o,
    output logic                   err_o
);

    // Two-state pairing FSM: waiting for a low byte, or holding one.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LO_HELD = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   strobe_prev_q;
    logic                   wr_evt;

    logic [0:0]             state_q;
    logic [7:0]             stage_q;
    logic [2:0]             pend_idx_q;

    logic [15:0]            regs_q [NUM_REGS];
    logic                   commit_q;
    logic [2:0]             commit_idx_q;
    logic                   err_q;

    logic [2:0]             wr_idx;
    logic                   wr_hi;
    logic                   wr_in_range;
    logic                   lo_wr;
    logic                   hi_pair_wr;
    logic                   hi_unpair_wr;
    logic                   range_err;

    // Strobe is asynchronous: shift it through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_i};
        end
    end

    // Remember the previous synchronized value for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_prev_q <= 1'b0;
        end else begin
            strobe_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // One write event per strobe, however long it stays high.
    assign wr_evt = sync_q[SYNC_STAGES-1] & ~strobe_prev_q;

    // Address and data are held stable by the sender, so sample them raw.
    assign wr_idx      = addr_i[3:1];
    assign wr_hi       = addr_i[0];
    assign wr_in_range = ({1'b0, wr_idx} < 4'(NUM_REGS));

    // Classify the write event against the current pairing state.
    always_comb begin
        lo_wr        = 1'b0;
        hi_pair_wr   = 1'b0;
        hi_unpair_wr = 1'b0;
        range_err    = 1'b0;
        if (wr_evt) begin
            if (!wr_in_range) begin
                range_err = 1'b1;
            end else if (!wr_hi) begin
                lo_wr = 1'b1;
            end else if ((state_q == ST_LO_HELD) && (pend_idx_q == wr_idx)) begin
                hi_pair_wr = 1'b1;
            end else begin
                hi_unpair_wr = 1'b1;
            end
        end
    end

    // Pairing state: a low write arms it, any in-range high write disarms it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (lo_wr) begin
            state_q <= ST_LO_HELD;
        end else if (hi_pair_wr || hi_unpair_wr) begin
            state_q <= ST_IDLE;
        end
    end

    // Staged low byte and its index; a repeated low write simply replaces them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q    <= '0;
            pend_idx_q <= '0;
        end else if (lo_wr) begin
            stage_q    <= data_i;
            pend_idx_q <= wr_idx;
        end
    end

    // Register bank: full 16-bit commit when paired, upper byte only when not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_idx == 3'(k)) begin
                    if (hi_pair_wr) begin
                        regs_q[k] <= {data_i, stage_q};
                    end else if (hi_unpair_wr) begin
                        regs_q[k][15:8] <= data_i;
                    end
                end
            end
        end
    end

    // Commit pulse lasts one cycle; the index holds until the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_q     <= 1'b0;
            commit_idx_q <= '0;
        end else begin
            commit_q <= hi_pair_wr | hi_unpair_wr;
            if (hi_pair_wr || hi_unpair_wr) begin
                commit_idx_q <= wr_idx;
            end
        end
    end

    // Sticky error; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (hi_unpair_wr || range_err) begin
            err_q <= 1'b1;
        end else if (err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    // Flatten the bank; register k sits at bits [16k+15:16k].
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[16*g +: 16] = regs_q[g];
    end

    assign commit_o     = commit_q;
    assign commit_idx_o = commit_idx_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_reg_write_receiver.sv
// Purpose: randomized self-checking bench for reg_write_receiver against a byte-pairing reference model.
// Latency: expects commit_o SYNC_STAGES edges after strobe_i is first sampled high.
// Backpressure: none; strobes are paced with at least SYNC_STAGES+1 high and low cycles.
module tb_reg_write_receiver;

    localparam int NUM_REGS    = 8;
    localparam int SYNC_STAGES = 2;
    localparam int LOW_GAP     = 6;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0]             data_i;
    logic [3:0]             addr_i;
    logic                   strobe_i;
    logic                   err_clr_i;
    logic [16*NUM_REGS-1:0] regs_o;
    logic                   commit_o;
    logic [2:0]             commit_idx_o;
    logic                   err_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what the register bank should hold after each write.
    logic [15:0] m_regs [NUM_REGS];
    bit          m_staged;
    logic [2:0]  m_pidx;
    logic [7:0]  m_stage;
    bit          m_err;
    logic [2:0]  m_last;

    reg_write_receiver #(
        .NUM_REGS    (NUM_REGS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .addr_i       (addr_i),
        .strobe_i     (strobe_i),
        .err_clr_i    (err_clr_i),
        .regs_o       (regs_o),
        .commit_o     (commit_o),
        .commit_idx_o (commit_idx_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
        m_staged = 0;
        m_pidx   = '0;
        m_stage  = '0;
        m_err    = 0;
        m_last   = '0;
    endtask

    // Apply one write to the model; clr models err_clr_i asserted at the event edge.
    task automatic model_apply(input logic [3:0] a, input logic [7:0] d, input bit clr,
                               output bit commit);
        logic [2:0] i;
        i      = a[3:1];
        commit = 0;
        if (clr) m_err = 0;
        if (int'(i) >= NUM_REGS) begin
            m_err = 1;
        end else if (!a[0]) begin
            m_staged = 1;
            m_pidx   = i;
            m_stage  = d;
        end else begin
            if (m_staged && m_pidx == i) begin
                m_regs[i] = {d, m_stage};
            end else begin
                m_regs[i][15:8] = d;
                m_err = 1;
            end
            m_staged = 0;
            m_last   = i;
            commit   = 1;
        end
    endtask

    task automatic check_state(input string tag);
        for (int k = 0; k < NUM_REGS; k++) begin
            chk($sformatf("%s.reg%0d", tag, k), 32'(regs_o[16*k +: 16]), 32'(m_regs[k]));
        end
        chk({tag, ".idx"}, 32'(commit_idx_o), 32'(m_last));
        chk({tag, ".err"}, 32'(err_o), 32'(m_err));
        chk({tag, ".commit"}, 32'(commit_o), 32'd0);
    endtask

    // One bus write: strobe high for 'hold' cycles, then low for LOW_GAP cycles.
    task automatic do_write(input string tag, input logic [3:0] a, input logic [7:0] d,
                            input int hold, input bit clr);
        bit exp_commit;
        int ncommit;
        int when;
        model_apply(a, d, clr, exp_commit);
        @(negedge clk);
        addr_i   = a;
        data_i   = d;
        strobe_i = 1'b1;
        ncommit  = 0;
        when     = 0;
        for (int c = 1; c <= hold; c++) begin
            @(negedge clk);
            if (commit_o) begin
                ncommit++;
                when = c;
            end
            // err_clr_i covers exactly the edge that registers the write event
            if (c == SYNC_STAGES) err_clr_i = clr;
            if (c == SYNC_STAGES + 1) err_clr_i = 1'b0;
        end
        strobe_i = 1'b0;
        for (int c = 1; c <= LOW_GAP; c++) begin
            @(negedge clk);
            if (commit_o) ncommit++;
        end
        chk({tag, ".ncommit"}, 32'(ncommit), 32'(exp_commit));
        if (exp_commit) chk({tag, ".latency"}, 32'(when), 32'(SYNC_STAGES + 1));
        check_state(tag);
    endtask

    task automatic do_clr(input string tag);
        @(negedge clk);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        m_err = 0;
        chk({tag, ".err"}, 32'(err_o), 32'd0);
    endtask

    // Assert reset away from any clock edge and check outputs clear at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".regs"}, 32'(regs_o == '0), 32'd1);
        chk({tag, ".commit"}, 32'(commit_o), 32'd0);
        chk({tag, ".err"}, 32'(err_o), 32'd0);
        chk({tag, ".idx"}, 32'(commit_idx_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] a;
        logic [2:0] k3;
        int         hold;
        rst       = 1'b1;
        data_i    = '0;
        addr_i    = '0;
        strobe_i  = 1'b0;
        err_clr_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_state("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_state("idle");

        // Paired write to register 1
        do_write("pair_lo", 4'h2, 8'hA5, 11, 0);
        do_write("pair_hi", 4'h3, 8'h5A, 11, 0);

        // Sweep indices 1..7 then 0
        for (int s = 0; s < NUM_REGS; s++) begin
            k3 = 3'((s + 1) % NUM_REGS);
            do_write("sweep_lo", {k3, 1'b0}, 8'hA5, 5, 0);
            do_write("sweep_hi", {k3, 1'b1}, 8'h5A, 5, 0);
        end

        // Unpaired high after reset, then clear the error
        do_reset("rst_mid");
        do_write("unpair", 4'h5, 8'h33, 5, 0);
        do_clr("clr1");

        // Low overwrite then matching high; then a stray high flags an error
        do_write("ovr_lo1", 4'h4, 8'h11, 5, 0);
        do_write("ovr_lo2", 4'h6, 8'h22, 5, 0);
        do_write("ovr_hi", 4'h7, 8'h99, 5, 0);
        do_write("stray_hi", 4'h5, 8'h44, 5, 0);

        // Clear and a new error in the same cycle: error stays set
        do_write("clr_vs_set", 4'h9, 8'h77, 5, 1);
        // Clear alongside a clean paired write: error drops
        do_write("clr_lo", 4'hA, 8'h01, 5, 0);
        do_write("clr_pair", 4'hB, 8'h02, 5, 1);

        // Long strobes give a single event each
        do_write("long_lo", 4'h8, 8'hC3, 40, 0);
        do_write("long_hi", 4'h9, 8'h3C, 40, 0);

        // Reset between a low and its high
        do_write("rst_lo", 4'hE, 8'h12, 5, 0);
        do_reset("rst_pair");
        do_write("rst_hi", 4'hF, 8'h34, 5, 0);
        do_clr("clr2");

        // Randomized traffic, biased towards valid pairs
        for (int n = 0; n < 60; n++) begin
            a    = 4'($urandom_range(0, 15));
            hold = $urandom_range(SYNC_STAGES + 2, 12);
            if ($urandom_range(0, 1) == 1) begin
                do_write("rnd_lo", {a[3:1], 1'b0}, 8'($urandom), hold, 0);
                if ($urandom_range(0, 9) == 0) do_reset("rnd_rst");
                do_write("rnd_hi", {a[3:1], 1'b1}, 8'($urandom), hold,
                         $urandom_range(0, 3) == 0);
            end else begin
                do_write("rnd", a, 8'($urandom), hold, $urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 7) == 0) do_clr("rnd_clr");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
